qracc_top: RTL and testbench

Digital top of the QR compute-in-memory accelerator. Contains a 4-entry CSR file on a control port, a byte-addressable global buffer on a 32-bit data port, and a sequencer. The sequencer streams input vectors from the buffer to the analog macro, scales the returned ADC codes, and writes the 8-bit outputs back to the buffer.

---
 rtl/qracc_top_if.sv | 33 +++
 rtl/qracc_top.sv | 235 +++++++++++++++++++++++
 tb/tb_qracc_top.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/qracc_top_if.sv
// Control-port and data-port signal bundle for the QR accelerator digital top.
// Latency: n/a (wiring only); the slave registers read data one cycle after a read.
// Backpressure: bus_ready low while the sequencer is busy; the control port never stalls.
interface qracc_top_if #(
  parameter int DW = 32,
  parameter int CW = 32,
  parameter int AW = 32
);
  logic [AW-1:0] periph_addr;
  logic          periph_wr;
  logic          periph_rd;
  logic [CW-1:0] periph_wdata;
  logic [CW-1:0] periph_rdata;

  logic [AW-1:0] bus_addr;
  logic          bus_wr;
  logic          bus_rd;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ready;

  modport master (
    output periph_addr, periph_wr, periph_rd, periph_wdata,
    output bus_addr, bus_wr, bus_rd, bus_wdata,
    input  periph_rdata, bus_rdata, bus_ready
  );

  modport slave (
    input  periph_addr, periph_wr, periph_rd, periph_wdata,
    input  bus_addr, bus_wr, bus_rd, bus_wdata,
    output periph_rdata, bus_rdata, bus_ready
  );
endinterface

// File: rtl/qracc_top.sv
// QR CIM accelerator digital top: CSR file, byte-addressed global buffer, vector sequencer.
// Latency: CSR/buffer reads 1 cycle; per vector LOAD+FIRE+WAIT(macro)+STORE.
// Backpressure: data port refused (bus_ready=0) while busy; macro paced by from_analog_done.
// Optional build macro QRACC_ADC_SHIFT_EN enables the CSR3[19:16] ADC left shift.
module qracc_top #(
  parameter int dataInterfaceSize     = 32,
  parameter int ctrlInterfaceSize     = 32,
  parameter int qrAccInputBits        = 4,
  parameter int qrAccInputElements    = 128,
  parameter int qrAccOutputBits       = 8,
  parameter int qrAccOutputElements   = 32,
  parameter int qrAccAdcBits          = 4,
  parameter int globalBufferDepth     = 2**21,
  parameter int globalBufferAddrWidth = 32
) (
  input  logic                 clk,
  input  logic                 nrst,
  qracc_top_if.slave           io,
  output logic [qrAccInputBits*qrAccInputElements-1:0] to_analog_data,
  output logic                 to_analog_start,
  input  logic [qrAccAdcBits*qrAccOutputElements-1:0]  from_analog_adc,
  input  logic                 from_analog_done,
  output logic [3*ctrlInterfaceSize-1:0] cfg,
  input  logic                 csr_main_clear,
  input  logic                 csr_main_start,
  output logic                 csr_main_busy,
  output logic                 csr_main_inst_write_mode
);

  localparam int LINE_W    = qrAccInputBits * qrAccInputElements;
  localparam int LINE_B    = LINE_W / 8;
  localparam int ADC_W     = qrAccAdcBits * qrAccOutputElements;
  localparam int OUT_B     = qrAccOutputElements * qrAccOutputBits / 8;
  localparam int BUF_AW    = $clog2(globalBufferDepth);
  localparam int WORD_B    = dataInterfaceSize / 8;
  localparam int SCL_W     = qrAccAdcBits + 15;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FIRE, S_WAIT, S_STORE} state_t;

  logic [7:0] mem_q [globalBufferDepth];

  state_t                         state_q;
  logic [15:0]                    n_q;
  logic                           busy_q;
  logic                           start_q;
  logic [LINE_W-1:0]              data_q;
  logic [ADC_W-1:0]               adc_q;
  logic                           start_prev_q;
  logic                           imode_q;
  logic [ctrlInterfaceSize-1:0]   csr1_q, csr2_q, csr3_q;
  logic [ctrlInterfaceSize-1:0]   periph_rdata_q;
  logic [dataInterfaceSize-1:0]   bus_rdata_q;

  logic [1:0]                     csr_idx;
  logic                           csr0_wr, start_req, clear_req;
  logic [15:0]                    n_total;
  logic [3:0]                     shamt;
  logic [globalBufferAddrWidth-1:0] ld_base, st_base;
  logic [LINE_W-1:0]              line_rd;
  logic [OUT_B*8-1:0]             store_line;
  logic [dataInterfaceSize-1:0]   bus_word;
  logic signed [SCL_W-1:0]        scaled;
  logic                           unused_ok;

  assign csr_idx   = io.periph_addr[3:2];
  assign csr0_wr   = io.periph_wr && (csr_idx == 2'd0);
  assign start_req = (csr0_wr && io.periph_wdata[0]) || (csr_main_start && !start_prev_q);
  assign clear_req = (csr0_wr && io.periph_wdata[2]) || csr_main_clear;
  assign n_total   = csr3_q[15:0];
  assign ld_base   = csr1_q + (32'(n_q) << 6);
  assign st_base   = csr2_q + (32'(n_q) << 5);
  assign unused_ok = ^{io.periph_addr[31:4], io.periph_addr[1:0]};

`ifdef QRACC_ADC_SHIFT_EN
  assign shamt = csr3_q[19:16];
`else
  assign shamt = 4'd0;
`endif

  assign to_analog_data           = data_q;
  assign to_analog_start          = start_q;
  assign cfg                      = {csr3_q, csr2_q, csr1_q};
  assign csr_main_busy            = busy_q;
  assign csr_main_inst_write_mode = imode_q;
  assign io.periph_rdata          = periph_rdata_q;
  assign io.bus_rdata             = bus_rdata_q;
  assign io.bus_ready             = ~busy_q;

  // Gather the 64-byte input line at the current ifmap address, wrapping in the buffer.
  always_comb begin
    line_rd = '0;
    for (int b = 0; b < LINE_B; b++) begin
      line_rd[8*b +: 8] = mem_q[BUF_AW'(ld_base + 32'(b))];
    end
  end

  // Gather the addressed little-endian data-port word.
  always_comb begin
    bus_word = '0;
    for (int b = 0; b < WORD_B; b++) begin
      bus_word[8*b +: 8] = mem_q[BUF_AW'(io.bus_addr + 32'(b))];
    end
  end

  // Scale each latched ADC code: sign-extend, shift left by S, saturate to int8.
  always_comb begin
    store_line = '0;
    scaled     = '0;
    for (int k = 0; k < qrAccOutputElements; k++) begin
      scaled = $signed({{15{adc_q[qrAccAdcBits*k + qrAccAdcBits-1]}},
                        adc_q[qrAccAdcBits*k +: qrAccAdcBits]}) <<< shamt;
      if (scaled > 19'sd127) begin
        store_line[8*k +: 8] = 8'h7F;
      end else if (scaled < -19'sd128) begin
        store_line[8*k +: 8] = 8'h80;
      end else begin
        store_line[8*k +: 8] = scaled[7:0];
      end
    end
  end

  // CSR file writes, start-pin edge history and registered CSR read data.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      imode_q        <= 1'b0;
      csr1_q         <= '0;
      csr2_q         <= '0;
      csr3_q         <= '0;
      start_prev_q   <= 1'b0;
      periph_rdata_q <= '0;
    end else begin
      start_prev_q <= csr_main_start;
      if (io.periph_rd) begin
        case (csr_idx)
          2'd0:    periph_rdata_q <= {28'd0, imode_q, 1'b0, busy_q, 1'b0};
          2'd1:    periph_rdata_q <= csr1_q;
          2'd2:    periph_rdata_q <= csr2_q;
          default: periph_rdata_q <= csr3_q;
        endcase
      end
      if (io.periph_wr) begin
        case (csr_idx)
          2'd0:    imode_q <= io.periph_wdata[3];
          2'd1:    csr1_q  <= io.periph_wdata;
          2'd2:    csr2_q  <= io.periph_wdata;
          default: csr3_q  <= io.periph_wdata;
        endcase
      end
    end
  end

  // Data-port read data; reads while busy return zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bus_rdata_q <= '0;
    end else if (io.bus_rd) begin
      bus_rdata_q <= busy_q ? '0 : bus_word;
    end
  end

  // Buffer writes: data-port words when idle, and the scaled output line in STORE.
  always_ff @(posedge clk) begin
    if (nrst && io.bus_wr && !busy_q) begin
      for (int b = 0; b < WORD_B; b++) begin
        mem_q[BUF_AW'(io.bus_addr + 32'(b))] <= io.bus_wdata[8*b +: 8];
      end
    end
    if (nrst && (state_q == S_STORE) && !clear_req) begin
      for (int k = 0; k < OUT_B; k++) begin
        mem_q[BUF_AW'(st_base + 32'(k))] <= store_line[8*k +: 8];
      end
    end
  end

  // Sequencer FSM with registered busy, start pulse, input line and ADC capture.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      data_q  <= '0;
      adc_q   <= '0;
    end else begin
      start_q <= 1'b0;
      if (clear_req) begin
        state_q <= S_IDLE;
        n_q     <= '0;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_req && !imode_q) begin
              state_q <= S_LOAD;
              n_q     <= '0;
              busy_q  <= 1'b1;
            end
          end
          S_LOAD: begin
            if (n_total == 16'd0) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              data_q  <= line_rd;
              start_q <= 1'b1;
              state_q <= S_FIRE;
            end
          end
          S_FIRE: state_q <= S_WAIT;
          S_WAIT: begin
            if (from_analog_done) begin
              adc_q   <= from_analog_adc;
              state_q <= S_STORE;
            end
          end
          S_STORE: begin
            if (n_q == n_total - 16'd1) begin
              state_q <= S_IDLE;
              n_q     <= '0;
              busy_q  <= 1'b0;
            end else begin
              n_q     <= n_q + 16'd1;
              state_q <= S_LOAD;
            end
          end
          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qracc_top.sv
// Directed self-checking bench for qracc_top with a behavioural analog-macro responder.
// Latency: checks one-cycle register reads and per-vector sequencing.
// Backpressure: exercises bus_ready=0 while busy.
module tb_qracc_top;
  logic         clk = 1'b0;
  logic         nrst;
  logic [511:0] to_analog_data;
  logic         to_analog_start;
  logic [127:0] from_analog_adc;
  logic         from_analog_done;
  logic [95:0]  cfg;
  logic         csr_main_clear, csr_main_start, csr_main_busy, csr_main_inst_write_mode;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  qracc_top_if bif ();

  qracc_top dut (
    .clk(clk), .nrst(nrst), .io(bif),
    .to_analog_data(to_analog_data), .to_analog_start(to_analog_start),
    .from_analog_adc(from_analog_adc), .from_analog_done(from_analog_done),
    .cfg(cfg), .csr_main_clear(csr_main_clear), .csr_main_start(csr_main_start),
    .csr_main_busy(csr_main_busy), .csr_main_inst_write_mode(csr_main_inst_write_mode)
  );

  always #5 clk = ~clk;

  // Analog macro model: records each requested line, answers after macro_delay cycles.
  int           start_cnt   = 0;
  int           skip_idx    = -1;
  int           macro_delay = 3;
  logic [127:0] adc_tab [4];
  logic [511:0] seen_line [4];

  initial begin
    from_analog_done = 1'b0;
    from_analog_adc  = '0;
    forever begin
      @(negedge clk);
      if (to_analog_start === 1'b1) begin
        int idx;
        idx = start_cnt;
        if (idx < 4) seen_line[idx] = to_analog_data;
        start_cnt = start_cnt + 1;
        if (idx != skip_idx) begin
          repeat (macro_delay) @(negedge clk);
          from_analog_adc  = adc_tab[idx % 4];
          from_analog_done = 1'b1;
          @(negedge clk);
          from_analog_done = 1'b0;
          from_analog_adc  = '0;
        end
      end
    end
  end

  task automatic periph_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bif.periph_addr = a; bif.periph_wdata = d; bif.periph_wr = 1'b1;
    @(negedge clk);
    bif.periph_wr = 1'b0;
  endtask

  task automatic periph_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bif.periph_addr = a; bif.periph_rd = 1'b1;
    @(negedge clk);
    bif.periph_rd = 1'b0;
    d = bif.periph_rdata;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bif.bus_addr = a; bif.bus_wdata = d; bif.bus_wr = 1'b1;
    @(negedge clk);
    bif.bus_wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bif.bus_addr = a; bif.bus_rd = 1'b1;
    @(negedge clk);
    bif.bus_rd = 1'b0;
    d = bif.bus_rdata;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (csr_main_busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    chk_cnt++; if (bif.bus_ready !== 1'b1) $display("FAIL reset_bus_ready: got %b want 1", bif.bus_ready); else pass_cnt++;
    chk_cnt++; if (csr_main_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", csr_main_busy); else pass_cnt++;
    chk_cnt++; if (to_analog_start !== 1'b0 || to_analog_data !== '0) $display("FAIL reset_analog: start %b data nonzero or X", to_analog_start); else pass_cnt++;
    chk_cnt++; if (cfg !== '0 || csr_main_inst_write_mode !== 1'b0) $display("FAIL reset_cfg: got %h mode %b want 0", cfg, csr_main_inst_write_mode); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      periph_read(32'(i * 4), r);
      chk_cnt++; if (r !== 32'h0) $display("FAIL reset_csr%0d: got %h want 00000000", i, r); else pass_cnt++;
    end
  endtask

  task automatic test_bus_rw();
    logic [31:0] r;
    bus_write(32'h100, 32'hA5A5_1234);
    bus_read(32'h100, r);
    chk_cnt++; if (r !== 32'hA5A5_1234) $display("FAIL bus_rw: got %h want a5a51234", r); else pass_cnt++;
  endtask

  task automatic test_single_vector();
    logic [31:0] r;
    bit ok;
    for (int i = 0; i < 16; i++) bus_write(32'(i * 4), 32'h2121_2121);
    bus_write(32'h1020, 32'hDEAD_BEEF);
    periph_write(32'h4, 32'h0);
    periph_write(32'h8, 32'h1000);
    periph_write(32'hC, 32'h1);
    adc_tab[0] = {32{4'h3}};
    start_cnt  = 0;
    periph_write(32'h0, 32'h1);
    chk_cnt++; if (csr_main_busy !== 1'b1) $display("FAIL single_busy_rise: got %b want 1", csr_main_busy); else pass_cnt++;
    wait_idle(200, ok);
    chk_cnt++; if (!ok) $display("FAIL single_timeout: busy still %b want 0", csr_main_busy); else pass_cnt++;
    chk_cnt++; if (start_cnt !== 1) $display("FAIL single_pulses: got %0d want 1", start_cnt); else pass_cnt++;
    chk_cnt++; if (seen_line[0] !== {64{8'h21}}) $display("FAIL single_line: got %h want all 21", seen_line[0]); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      bus_read(32'h1000 + 32'(i * 4), r);
      chk_cnt++; if (r !== 32'h0303_0303) $display("FAIL single_out%0d: got %h want 03030303", i, r); else pass_cnt++;
    end
    bus_read(32'h1020, r);
    chk_cnt++; if (r !== 32'hDEAD_BEEF) $display("FAIL single_past_end: got %h want deadbeef", r); else pass_cnt++;
  endtask

  task automatic test_shift();
    logic [31:0] r;
    logic [31:0] exp_a, exp_b;
    bit ok;
`ifdef QRACC_ADC_SHIFT_EN
    exp_a = 32'h807F_807F;
    exp_b = 32'hC040_C040;
`else
    exp_a = 32'hF807_F807;
    exp_b = 32'hFF01_FF01;
`endif
    adc_tab[0] = {16{8'h87}};
    adc_tab[1] = {16{8'hF1}};
    periph_write(32'hC, (32'd6 << 16) | 32'd2);
    start_cnt = 0;
    periph_write(32'h0, 32'h1);
    wait_idle(300, ok);
    chk_cnt++; if (!ok || start_cnt !== 2) $display("FAIL shift_run: done %b pulses %0d want 1/2", ok, start_cnt); else pass_cnt++;
    bus_read(32'h1000, r);
    chk_cnt++; if (r !== exp_a) $display("FAIL shift_sat: got %h want %h", r, exp_a); else pass_cnt++;
    bus_read(32'h103C, r);
    chk_cnt++; if (r !== exp_b) $display("FAIL shift_signed: got %h want %h", r, exp_b); else pass_cnt++;
    periph_read(32'hC, r);
    chk_cnt++; if (r !== 32'h0006_0002) $display("FAIL shift_csr3_rb: got %h want 00060002", r); else pass_cnt++;
  endtask

  task automatic test_multi();
    logic [31:0]  r;
    logic [511:0] exp_line;
    logic [7:0]   bv;
    bit ok;
    for (int a = 0; a < 192; a += 4) begin
      bv = 8'(a);
      bus_write(32'(a), {bv + 8'd3, bv + 8'd2, bv + 8'd1, bv});
    end
    for (int i = 0; i < 3; i++) adc_tab[i] = {32{4'(i + 1)}};
    periph_write(32'h4, 32'h0);
    periph_write(32'h8, 32'h2000);
    periph_write(32'hC, 32'h3);
    start_cnt = 0;
    @(negedge clk);
    csr_main_start = 1'b1;
    wait_idle(2, ok);
    wait_idle(500, ok);
    chk_cnt++; if (!ok) $display("FAIL multi_timeout: busy %b want 0", csr_main_busy); else pass_cnt++;
    repeat (5) @(negedge clk);
    csr_main_start = 1'b0;
    chk_cnt++; if (start_cnt !== 3) $display("FAIL multi_pulses: got %0d want 3", start_cnt); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      for (int b = 0; b < 64; b++) exp_line[8*b +: 8] = 8'(64 * i + b);
      chk_cnt++; if (seen_line[i] !== exp_line) $display("FAIL multi_line%0d: got %h want %h", i, seen_line[i][63:0], exp_line[63:0]); else pass_cnt++;
      bus_read(32'h2000 + 32'(32 * i), r);
      chk_cnt++; if (r !== {4{8'(i + 1)}}) $display("FAIL multi_out%0d: got %h want %h", i, r, {4{8'(i + 1)}}); else pass_cnt++;
    end
  endtask

  task automatic test_clear();
    logic [31:0] r;
    bit ok;
    for (int a = 0; a < 96; a += 4) bus_write(32'h3000 + 32'(a), 32'hEEEE_EEEE);
    periph_write(32'h8, 32'h3000);
    periph_write(32'hC, 32'h3);
    adc_tab[0] = {32{4'h1}};
    skip_idx  = 1;
    start_cnt = 0;
    periph_write(32'h0, 32'h1);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (start_cnt == 2) begin ok = 1'b1; break; end
    end
    chk_cnt++; if (!ok) $display("FAIL clear_reach_wait: pulses %0d want 2", start_cnt); else pass_cnt++;
    repeat (2) @(negedge clk);
    csr_main_clear = 1'b1;
    @(negedge clk);
    csr_main_clear = 1'b0;
    chk_cnt++; if (csr_main_busy !== 1'b0) $display("FAIL clear_idle: busy %b want 0", csr_main_busy); else pass_cnt++;
    repeat (10) @(negedge clk);
    skip_idx = -1;
    chk_cnt++; if (start_cnt !== 2) $display("FAIL clear_no_more: pulses %0d want 2", start_cnt); else pass_cnt++;
    bus_read(32'h3000, r);
    chk_cnt++; if (r !== 32'h0101_0101) $display("FAIL clear_line0: got %h want 01010101", r); else pass_cnt++;
    bus_read(32'h3020, r);
    chk_cnt++; if (r !== 32'hEEEE_EEEE) $display("FAIL clear_line1: got %h want eeeeeeee", r); else pass_cnt++;
  endtask

  task automatic test_inst_mode();
    logic [31:0] r;
    periph_write(32'h0, 32'h8);
    periph_read(32'h0, r);
    chk_cnt++; if (r !== 32'h8 || csr_main_inst_write_mode !== 1'b1) $display("FAIL imode_rb: got %h mode %b want 8/1", r, csr_main_inst_write_mode); else pass_cnt++;
    start_cnt = 0;
    periph_write(32'h0, 32'h9);
    repeat (3) @(negedge clk);
    chk_cnt++; if (csr_main_busy !== 1'b0 || start_cnt !== 0) $display("FAIL imode_block: busy %b pulses %0d want 0/0", csr_main_busy, start_cnt); else pass_cnt++;
    periph_write(32'h0, 32'h0);
    chk_cnt++; if (csr_main_inst_write_mode !== 1'b0) $display("FAIL imode_clr: got %b want 0", csr_main_inst_write_mode); else pass_cnt++;
  endtask

  task automatic test_busy_bus();
    logic [31:0] r;
    bit ok;
    bus_write(32'h200, 32'h1111_1111);
    periph_write(32'hC, 32'h1);
    macro_delay = 12;
    periph_write(32'h0, 32'h1);
    chk_cnt++; if (bif.bus_ready !== 1'b0) $display("FAIL busy_ready: got %b want 0", bif.bus_ready); else pass_cnt++;
    bus_write(32'h200, 32'h2222_2222);
    bus_read(32'h200, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL busy_rdata: got %h want 00000000", r); else pass_cnt++;
    periph_read(32'h0, r);
    chk_cnt++; if (r !== 32'h2) $display("FAIL busy_csr0: got %h want 00000002", r); else pass_cnt++;
    wait_idle(200, ok);
    macro_delay = 3;
    bus_read(32'h200, r);
    chk_cnt++; if (!ok || r !== 32'h1111_1111) $display("FAIL busy_ignored: got %h want 11111111", r); else pass_cnt++;
  endtask

  task automatic test_n_zero();
    int busy_cycles;
    periph_write(32'hC, 32'h0);
    start_cnt = 0;
    periph_write(32'h0, 32'h1);
    busy_cycles = (csr_main_busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (csr_main_busy === 1'b1) busy_cycles++;
    end
    chk_cnt++; if (busy_cycles !== 1) $display("FAIL nzero_busy: got %0d cycles want 1", busy_cycles); else pass_cnt++;
    chk_cnt++; if (start_cnt !== 0) $display("FAIL nzero_pulses: got %0d want 0", start_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    logic [31:0] r;
    periph_write(32'h4, 32'h40);
    periph_write(32'hC, 32'h3);
    macro_delay = 8;
    periph_write(32'h0, 32'h1);
    repeat (4) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    chk_cnt++; if (csr_main_busy !== 1'b0 || bif.bus_ready !== 1'b1) $display("FAIL rst_mid_idle: busy %b ready %b want 0/1", csr_main_busy, bif.bus_ready); else pass_cnt++;
    repeat (15) @(negedge clk);
    macro_delay = 3;
    periph_read(32'h4, r);
    chk_cnt++; if (r !== 32'h0) $display("FAIL rst_mid_csr1: got %h want 00000000", r); else pass_cnt++;
    bus_read(32'h100, r);
    chk_cnt++; if (r !== 32'hA5A5_1234) $display("FAIL rst_mid_retain: got %h want a5a51234", r); else pass_cnt++;
  endtask

  task automatic test_wrap();
    logic [31:0] r;
    bus_write(32'h0020_0100, 32'h5A5A_5A5A);
    bus_read(32'h100, r);
    chk_cnt++; if (r !== 32'h5A5A_5A5A) $display("FAIL wrap: got %h want 5a5a5a5a", r); else pass_cnt++;
  endtask

  initial begin
    nrst = 1'b0;
    csr_main_clear = 1'b0;
    csr_main_start = 1'b0;
    bif.periph_addr = '0; bif.periph_wr = 1'b0; bif.periph_rd = 1'b0; bif.periph_wdata = '0;
    bif.bus_addr = '0; bif.bus_wr = 1'b0; bif.bus_rd = 1'b0; bif.bus_wdata = '0;
    for (int i = 0; i < 4; i++) begin adc_tab[i] = '0; seen_line[i] = '0; end
    test_reset();
    test_bus_rw();
    test_single_vector();
    test_shift();
    test_multi();
    test_clear();
    test_inst_mode();
    test_busy_bus();
    test_n_zero();
    test_reset_midop();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
